// File: rtl/aes_128_stream_ctrl_if.sv
// rtl/aes_128_stream_ctrl_if.sv - block stream bundle (input blocks, output results); AES_STREAM_TAG_EN adds tags
interface aes_128_stream_ctrl_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_state;
   logic [127:0] in_key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
`ifdef AES_STREAM_TAG_EN
   logic [7:0]   in_tag;
   logic [7:0]   out_tag;

   modport master (
      output in_valid, in_state, in_key, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag
   );
   modport slave (
      input  in_valid, in_state, in_key, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag
   );
`else
   modport master (
      output in_valid, in_state, in_key, out_ready,
      input  in_ready, out_valid, out_data
   );
   modport slave (
      input  in_valid, in_state, in_key, out_ready,
      output in_ready, out_valid, out_data
   );
`endif
endinterface

// File: rtl/aes_128_stream_ctrl.sv
// rtl/aes_128_stream_ctrl.sv - valid/ready wrapper with credit-protected result FIFO around a non-stallable aes_128 core
// Optional tag passthrough is enabled by defining AES_STREAM_TAG_EN.
module aes_128_stream_ctrl #(
   parameter int LATENCY = 21,
   parameter int DEPTH   = 32,
   parameter int AW      = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   aes_128_stream_ctrl_if.slave s,
   output logic [127:0]         core_state,
   output logic [127:0]         core_key,
   input  logic [127:0]         core_out,
   output logic                 busy
);
   localparam logic [AW:0] FULL = DEPTH[AW:0];

   logic [AW:0]        used;
   logic [AW:0]        fifo_cnt;
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [LATENCY-1:0] tok;
   logic               acc;
   logic               pop;
   logic               wr_en;
   logic [127:0]       mem [DEPTH];

   assign core_state = s.in_state;
   assign core_key   = s.in_key;

   // Credits cover in-flight plus queued blocks, so a token leaving the core always finds a free slot.
   assign s.in_ready  = (used < FULL);
   assign acc         = s.in_valid & s.in_ready;
   assign s.out_valid = (fifo_cnt != '0);
   assign pop         = s.out_valid & s.out_ready;
   assign wr_en       = tok[LATENCY-1];
   assign busy        = (used != '0);
   assign s.out_data  = s.out_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tok <= '0;
      end else begin
         tok <= {tok[LATENCY-2:0], acc};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         used <= '0;
      end else begin
         used <= used + {{AW{1'b0}}, acc} - {{AW{1'b0}}, pop};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         fifo_cnt <= fifo_cnt + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= core_out;
      end
   end

`ifdef AES_STREAM_TAG_EN
   logic [7:0] tag_dly [LATENCY];
   logic [7:0] tag_mem [DEPTH];

   assign s.out_tag = s.out_valid ? tag_mem[rd_ptr] : '0;

   // Tag rides alongside the token so it lines up with core_out on the FIFO write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LATENCY; i++) begin
            tag_dly[i] <= '0;
         end
      end else begin
         tag_dly[0] <= s.in_tag;
         for (int i = 1; i < LATENCY; i++) begin
            tag_dly[i] <= tag_dly[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[wr_ptr] <= tag_dly[LATENCY-1];
      end
   end
`endif
endmodule

// File: tb/tb_aes_128_stream_ctrl.sv
// tb/tb_aes_128_stream_ctrl.sv - self-checking bench with behavioural AES core and scoreboard
module tb_aes_128_stream_ctrl;
   localparam int LATENCY = 21;
   localparam int DEPTH   = 32;

   typedef struct {
      logic [127:0] st;
      logic [127:0] key;
      logic [127:0] ct;
   } vec_t;

   typedef struct {
      logic [127:0] data;
      logic [7:0]   tag;
      longint       due;
   } sb_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] core_state;
   logic [127:0] core_key;
   logic [127:0] core_out;
   logic         busy;

   int     checks = 0;
   int     errors = 0;
   longint edges = 0;
   int     m_used = 0;
   sb_t    sbq [$];
   logic   exp_ov;
   vec_t   vt [5];
   logic [127:0] pipe [LATENCY];
   logic [7:0]   sbox [256];

   aes_128_stream_ctrl_if bus ();

   aes_128_stream_ctrl #(.LATENCY(LATENCY), .DEPTH(DEPTH), .AW(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .s          (bus),
      .core_state (core_state),
      .core_key   (core_key),
      .core_out   (core_out),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   initial begin
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv;
         logic [7:0] b;
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         b = inv;
         sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      end
   end

   function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [31:0]  w [4];
      logic [7:0]   rc;
      logic [31:0]  tmp;
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] res;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
      rc = 8'h01;
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
         for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) s[c*4+rr] = t[((c+rr)%4)*4+rr];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[c*4]; a1 = s[c*4+1]; a2 = s[c*4+2]; a3 = s[c*4+3];
               s[c*4]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
               s[c*4+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
               s[c*4+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
               s[c*4+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
            end
         end
         tmp = w[3];
         tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
         w[0] = w[0] ^ tmp;
         w[1] = w[1] ^ w[0];
         w[2] = w[2] ^ w[1];
         w[3] = w[3] ^ w[2];
         rc = xt(rc);
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i/4][31-8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   // Fixed-latency, non-stallable core: samples every edge.
   always @(posedge clk) begin
      pipe[0] <= aes_ref(core_state, core_key);
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
      edges <= edges + 1;
   end
   assign core_out = pipe[LATENCY-1];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_rand();
      bus.in_state = {$urandom, $urandom, $urandom, $urandom};
      bus.in_key   = {$urandom, $urandom, $urandom, $urandom};
`ifdef AES_STREAM_TAG_EN
      bus.in_tag   = 8'($urandom);
`endif
   endtask

   task automatic drain();
      int n;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      n = 0;
      while (busy && n < 300) begin
         tick();
         n++;
      end
      chk("drain_idle", busy, 1'b0);
   endtask

   // Scoreboard: model tracks credits and each block's due time, independent of DUT structure.
   always @(negedge clk) begin
      if (rst) begin
         sbq.delete();
         m_used = 0;
      end else begin
         exp_ov = (sbq.size() != 0) && (sbq[0].due <= edges);
         chk("in_ready", bus.in_ready, m_used < DEPTH);
         chk("busy", busy, m_used != 0);
         chk("out_valid", bus.out_valid, exp_ov);
         if (bus.out_valid && sbq.size() != 0) begin
            chk("out_data", bus.out_data, sbq[0].data);
`ifdef AES_STREAM_TAG_EN
            chk("out_tag", bus.out_tag, sbq[0].tag);
`endif
         end
         if (dut.tok[LATENCY-1]) chk("fifo_room_on_write", dut.fifo_cnt == DEPTH, 1'b0);
         if (bus.in_valid && bus.in_ready) begin
`ifdef AES_STREAM_TAG_EN
            sbq.push_back('{aes_ref(bus.in_state, bus.in_key), bus.in_tag, edges + 1 + LATENCY});
`else
            sbq.push_back('{aes_ref(bus.in_state, bus.in_key), 8'h00, edges + 1 + LATENCY});
`endif
            m_used++;
         end
         if (bus.out_valid && bus.out_ready) begin
            chk("pop_expected", sbq.size() != 0, 1'b1);
            if (sbq.size() != 0) void'(sbq.pop_front());
            m_used--;
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL global_timeout actual=%0d required=done", edges);
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      int n;
      int acc_n;
      int stale;
      int b2b [5];
      vt[0] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32};
      vt[1] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
      vt[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
      vt[3] = '{128'h0, 128'h1, 128'h0545aad56da2a97c3663d1432a3d1c84};
      vt[4] = '{128'h1, 128'h0, 128'h58e2fccefa7e3061367f1d57a4e7455a};
      b2b = '{1, 2, 3, 4, 1};

      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.in_state  = '0;
      bus.in_key    = '0;
`ifdef AES_STREAM_TAG_EN
      bus.in_tag    = '0;
`endif
      repeat (3) tick();
      chk("rst_in_ready", bus.in_ready, 1'b1);
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_out_data", bus.out_data, 128'h0);
`ifdef AES_STREAM_TAG_EN
      chk("rst_out_tag", bus.out_tag, 8'h00);
`endif
      rst = 1'b0;
      tick();

      // single FIPS-197 block and its latency
      bus.in_state = vt[0].st;
      bus.in_key   = vt[0].key;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 100) begin
         tick();
         n++;
      end
      chk("fips_latency", n, LATENCY);
      chk("fips_data", bus.out_data, vt[0].ct);
      bus.out_ready = 1'b1;
      tick();
      chk("fips_popped", bus.out_valid, 1'b0);

      // back-to-back table vectors, results on consecutive cycles
      for (int i = 0; i < 5; i++) begin
         bus.in_state = vt[b2b[i]].st;
         bus.in_key   = vt[b2b[i]].key;
`ifdef AES_STREAM_TAG_EN
         bus.in_tag   = 8'(i);
`endif
         bus.in_valid = 1'b1;
         tick();
      end
      bus.in_valid = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 100) begin
         tick();
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         chk("b2b_valid", bus.out_valid, 1'b1);
         chk("b2b_data", bus.out_data, vt[b2b[i]].ct);
`ifdef AES_STREAM_TAG_EN
         chk("b2b_tag", bus.out_tag, 8'(i));
`endif
         tick();
      end
      chk("b2b_empty", bus.out_valid, 1'b0);

      // randomized traffic against the scoreboard
      for (int i = 0; i < 600; i++) begin
         drive_rand();
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.out_ready = ($urandom_range(0, 2) != 0);
         tick();
      end
      drain();

      // backpressure until full
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      acc_n = 0;
      for (int i = 0; i < 60; i++) begin
         drive_rand();
         if (bus.in_ready) acc_n++;
         tick();
      end
      chk("full_accepts", acc_n, DEPTH);
      chk("full_in_ready", bus.in_ready, 1'b0);
      chk("full_busy", busy, 1'b1);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      chk("full_ready_after_pop", bus.in_ready, 1'b1);
      acc_n = 1;
      n = 0;
      while (bus.out_valid && n < 100) begin
         tick();
         acc_n++;
         n++;
      end
      chk("full_pops", acc_n, DEPTH);

      // accept + pop together at used = DEPTH-1
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      for (int i = 0; i < 60; i++) begin
         drive_rand();
         tick();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      chk("sim_used31_ready", bus.in_ready, 1'b1);
      drive_rand();
      bus.in_valid  = 1'b1;
      tick();
      chk("sim_ready_kept", bus.in_ready, 1'b1);
      chk("sim_used", dut.used, 31);
      bus.out_ready = 1'b0;
      acc_n = 0;
      for (int i = 0; i < 30; i++) begin
         drive_rand();
         if (bus.in_ready) acc_n++;
         tick();
      end
      chk("sim_one_more", acc_n, 1);
      drain();

      // reset with 3 queued and 10 in flight
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_rand();
         tick();
      end
      bus.in_valid = 1'b0;
      repeat (25) tick();
      bus.in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive_rand();
         tick();
      end
      bus.in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", bus.out_valid, 1'b0);
      chk("midrst_in_ready", bus.in_ready, 1'b1);
      chk("midrst_busy", busy, 1'b0);
      tick();
      rst = 1'b0;
      bus.out_ready = 1'b1;
      stale = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (bus.out_valid) stale++;
      end
      chk("midrst_no_stale", stale, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/aes_128_stream_ctrl.md
# aes_128_stream_ctrl

Valid/ready streaming front-end and back-end for the fixed-latency, non-stallable `aes_128` pipeline core. Accepts (state, key) blocks over a valid/ready handshake and drives them straight into the core. It tracks each block through the core with a token delay line and captures results into an output FIFO with backpressure. A credit counter guarantees no result is ever lost, even though the core cannot stall.

## Interface
Parameters:
- `LATENCY`, 21: cycles from the core sampling `state`/`key` until `out` holds that block's result; matches `aes_128`.
- `DEPTH`, 32: output FIFO entries; power of two, ≥ 2; `DEPTH ≥ LATENCY+1` for full throughput.
- `AW`, 5: log2(`DEPTH`).

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream block valid.
- `in_ready`  out  1  block accepted on a rising edge when `in_valid && in_ready`.
- `in_state`  in  128  plaintext.
- `in_key`  in  128  cipher key.
- `core_state`  out  128  to `aes_128.state`; combinational copy of `in_state`.
- `core_key`  out  128  to `aes_128.key`; combinational copy of `in_key`.
- `core_out`  in  128  from `aes_128.out`.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  downstream pop; a pop occurs when `out_valid && out_ready`.
- `out_data`  out  128  FIFO head ciphertext.
- `busy`  out  1  `used != 0`.

## Operation
- **Accept:** `acc = in_valid & in_ready`. The core samples `core_state`/`core_key` on every edge regardless of `acc`; non-accepted cycles inject garbage that is never captured.
- **Token line:** `tok[LATENCY-1:0]` shifts every cycle, with `tok[0] <= acc`. When `tok[LATENCY-1]=1`, `core_out` holds a valid result, and the FIFO writes `core_out` on that edge.
- **Credit counter:**
  - `used` (width AW+1) counts blocks in flight plus blocks in the FIFO.
  - `used <= used + acc - pop`.
  - `in_ready = (used < DEPTH)`.
  - Because of this rule the FIFO write can never find the FIFO full. The bench asserts this.
- **FIFO:**
  - Circular buffer with wr_ptr/rd_ptr (AW bits, wrap modulo DEPTH) and a count.
  - Write and pop in the same cycle are both honoured; the count is unchanged.
  - Pop on empty is impossible because `out_valid=0`.
  - `out_data` is the head entry. It is registered read data or a mux, but it must be stable while `out_valid && !out_ready`.
- **Simultaneous events:**
  - Accept + pop with `used==DEPTH`: `in_ready` is already 0, so only the pop occurs.
  - Accept + pop otherwise: `used` is unchanged.
- No state machine beyond the counters. Ordering is strictly FIFO; results leave in acceptance order.

## Timing
- **Reset values:** `in_ready=1`, `out_valid=0`, `busy=0`, `out_data=0`, `tok=0`, `used=0`, pointers 0.
- **Reset mid-operation:** all in-flight and queued blocks are dropped. Results still in the core pipeline are ignored because their tokens are cleared.
- **Latency:**
  - A block accepted at edge k is written to the FIFO at edge k+LATENCY.
  - `out_valid` rises after edge k+LATENCY, when the FIFO was empty.
  - Total: LATENCY cycles from acceptance to `out_valid`.
- **Throughput:** one block per cycle sustained while `out_ready=1`.
- **`in_ready` timing:** depends only on registered `used`; there is no combinational path from `out_ready` to `in_ready`.

## Configuration
- Macro: `AES_STREAM_TAG_EN`.
- **Defined:**
  - Adds ports `in_tag` (in, 8) and `out_tag` (out, 8).
  - The tag travels in a parallel LATENCY-deep delay line with the token and is stored in the FIFO alongside the data.
  - `out_tag` resets to 0.
- **Undefined:** no tag ports, tag delay line or tag storage; behaviour is otherwise identical.

## Test plan
- **Single FIPS-197 vector:**
  - Stimulus: reset, then accept state `3243f6a8885a308d313198a2e0370734` with key `2b7e151628aed2a6abf7158809cf4f3c`.
  - Response: `out_valid` exactly 21 cycles later, `out_data=3925841d02dc09fbdc118597196a0b32`.
- **Back-to-back stream:**
  - Stimulus: five consecutive accepts of (state, key) pairs: (`00112233445566778899aabbccddeeff`, `000102030405060708090a0b0c0d0e0f`), (0, 0), (0, 1), (1, 0); then repeat the first vector.
  - Response, in order: `69c4e0d86a7b0430d8cdb78070b4c55a`, `66e94bd4ef8a2c3b884cfa59ca342b2e`, `0545aad56da2a97c3663d1432a3d1c84`, `58e2fccefa7e3061367f1d57a4e7455a`, `69c4e0d8…`, on consecutive cycles.
- **Backpressure full:**
  - Stimulus: `out_ready=0`, `in_valid=1` held.
  - Response: exactly 32 accepts, then `in_ready=0`. No FIFO overflow, `busy=1`.
  - Stimulus: raise `out_ready`.
  - Response: 32 results in order, `in_ready` returns to 1 the cycle after the first pop.
- **Simultaneous accept+pop at `used=31`:** `used` stays 31 and `in_ready` stays 1.
- **Reset mid-stream:**
  - Stimulus: assert `rst` with 10 blocks in flight and 3 in the FIFO.
  - Response: immediately `out_valid=0`, `in_ready=1`. No stale result appears in the following 30 cycles.
- **`AES_STREAM_TAG_EN` build:** tags `0x00..0x04` on the five blocks of the back-to-back scenario return in order, aligned with their ciphertexts.
